pc_sequencer: RTL

//  Registered program-counter unit for the LEGv8 datapath: holds PC, computes next PC from

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the LEGv8 program-counter sequencer.
// Branch-mode encodings, instruction size and the next-PC source select live here.
package pc_seq_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_BYTES = 4;

  localparam logic BR_CBZ  = 1'b0;
  localparam logic BR_CBNZ = 1'b1;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_REL = 2'd1,
    SEL_REG = 2'd2
  } pc_sel_e;

  // CBZ takes the branch on a zero result, CBNZ on a non-zero result.
  function automatic logic br_cond_met(input logic br_mode, input logic alu_zero);
    return (br_mode == BR_CBNZ) ? !alu_zero : alu_zero;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with saturating occupancy count.
// A push into a full stack overwrites the oldest entry; a pop of an empty stack is ignored.
module pc_ras #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
  endfunction

  // wr_ptr always names the next free slot, so the top sits one behind it.
  assign top_ptr = ptr_dec(wr_ptr_q);
  assign top     = mem_q[top_ptr];
  assign empty   = (count_q == '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      if (count_q != CNT_W'(DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC unit: sequential, conditional, unconditional and register branches with stall.
// Define PC_RAS_EN to add a return-address stack used by BL (push) and RET (pop).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter logic [63:0] RESET_VEC = 64'h0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Branch,
  input  logic              BrMode,
  input  logic              ALUZero,
  input  logic              Uncondbranch,
  input  logic              Link,
  input  logic              RegBranch,
  input  logic              Ret,
  input  logic [ADDR_W-1:0] SignExtImm,
  input  logic [ADDR_W-1:0] RegTarget,
  output logic [ADDR_W-1:0] FetchPC,
  output logic [ADDR_W-1:0] LinkAddr,
  output logic              Taken,
  output logic              Misalign
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              misalign_q, misalign_d;

  pc_sel_e           sel;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] rel_pc;
  logic [ADDR_W-1:0] reg_pc;
  logic [ADDR_W-1:0] next_pc;

  assign seq_pc   = pc_q + ADDR_W'(INSTR_BYTES);
  assign rel_pc   = pc_q + (SignExtImm << 2);
  assign LinkAddr = seq_pc;

  always_comb begin
    sel = SEL_SEQ;
    if (RegBranch) begin
      sel = SEL_REG;
    end else if (Uncondbranch) begin
      sel = SEL_REL;
    end else if (Branch && br_cond_met(BrMode, ALUZero)) begin
      sel = SEL_REL;
    end
  end

`ifdef PC_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;

  // RegBranch outranks Uncondbranch, so a push and a pop can never coincide.
  assign ras_push = !Stall && !RegBranch && Uncondbranch && Link;
  assign ras_pop  = !Stall && RegBranch && Ret;
  assign reg_pc   = (Ret && !ras_empty) ? ras_top : RegTarget;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  localparam int UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_ras_inputs;

  assign unused_ras_inputs = Ret ^ Link;
  assign reg_pc            = RegTarget;
`endif

  always_comb begin
    unique case (sel)
      SEL_REL: next_pc = rel_pc;
      SEL_REG: next_pc = reg_pc;
      default: next_pc = seq_pc;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    taken_d    = taken_q;
    misalign_d = misalign_q;
    if (!Stall) begin
      pc_d       = next_pc;
      taken_d    = (sel != SEL_SEQ);
      // A misaligned target is still loaded as-is; the trap is raised upstream.
      misalign_d = (next_pc[1:0] != 2'b00);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q       <= ADDR_W'(RESET_VEC);
      taken_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      taken_q    <= taken_d;
      misalign_q <= misalign_d;
    end
  end

  assign FetchPC  = pc_q;
  assign Taken    = taken_q;
  assign Misalign = misalign_q;

endmodule
